// File: rtl/head_sram_if_master.sv
// Line-to-beat initiator for the 16-bit debug/load port of head_sram: one 128-bit
// line request becomes 8 registered interface beats; read beats are reassembled.
module head_sram_if_master #(
  parameter  int BANK_DEPTH = 32,
  parameter  int DATA_WIDTH = 128,
  localparam int LINE_W     = $clog2(BANK_DEPTH),
  localparam int ADDR_W     = LINE_W + 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [LINE_W-1:0]     req_line,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_wr,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_W-1:0]     interface_addr,
  output logic                  interface_ren,
  output logic                  interface_wen,
  output logic [15:0]           interface_wdata,
  input  logic [15:0]           interface_rdata,
  input  logic                  interface_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            bc_q, bc_d;
  logic [LINE_W-1:0]     line_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wline_q;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [2:0]            rc_q;
  logic                  cap_done_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic       accept;
  logic       capture;
  logic       last_beat;
  logic       last_capture;
  logic [2:0] beat_nxt;

  assign accept       = req_valid && (state_q == S_IDLE);
  assign capture      = interface_rvalid && ((state_q == S_RD_ISSUE) || (state_q == S_RD_DRAIN));
  assign last_beat    = (bc_q == 3'd7);
  assign last_capture = capture && (rc_q == 3'd7);
  assign beat_nxt     = bc_q + 3'd1;

  // State register plus every registered output and the latched request.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      bc_q      <= 3'd0;
      line_q    <= '0;
      wr_q      <= 1'b0;
      wline_q   <= '0;
      addr_q    <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= 16'h0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      addr_q    <= addr_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      if (accept) begin
        line_q  <= req_line;
        wr_q    <= req_wr;
        wline_q <= req_wdata;
      end
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (accept) state_d = req_wr ? S_WR_ISSUE : S_RD_ISSUE;
      S_WR_ISSUE: if (last_beat) state_d = S_RESP;
      S_RD_ISSUE: if (last_beat) state_d = S_RD_DRAIN;
      S_RD_DRAIN: if (cap_done_q || last_capture) state_d = S_RESP;
      S_RESP:     if (resp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the values the interface registers take on the next edge.
  always_comb begin
    bc_d    = bc_q;
    addr_d  = addr_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          bc_d    = 3'd0;
          addr_d  = {req_line, 3'd0};
          wen_d   = req_wr;
          ren_d   = !req_wr;
          wdata_d = req_wdata[15:0];
        end
      end
      S_WR_ISSUE, S_RD_ISSUE: begin
        if (!last_beat) begin
          bc_d   = beat_nxt;
          addr_d = {line_q, beat_nxt};
          wen_d  = (state_q == S_WR_ISSUE);
          ren_d  = (state_q == S_RD_ISSUE);
          if (state_q == S_WR_ISSUE) wdata_d = wline_q[{beat_nxt, 4'b0} +: 16];
        end
      end
      default: ;
    endcase
  end

  // Read-return capture; rvalid outside the read states is deliberately dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rc_q       <= 3'd0;
      cap_done_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) cap_done_q <= 1'b0;
      if (capture) begin
        rdata_q[{rc_q, 4'b0} +: 16] <= interface_rdata;
        rc_q                        <= rc_q + 3'd1;
        if (rc_q == 3'd7) cap_done_q <= 1'b1;
      end
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_wr         = wr_q;
  assign resp_rdata      = rdata_q;
  assign interface_addr  = addr_q;
  assign interface_ren   = ren_q;
  assign interface_wen   = wen_q;
  assign interface_wdata = wdata_q;

endmodule

// File: tb/tb_head_sram_if_master.sv
// Directed bench for head_sram_if_master with a small head_sram interface-port model
// (writes on the strobe edge, read data returned two cycles after the read strobe).
module tb_head_sram_if_master;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [4:0]   req_line;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_wr;
  logic [127:0] resp_rdata;
  logic [7:0]   interface_addr;
  logic         interface_ren;
  logic         interface_wen;
  logic [15:0]  interface_wdata;
  logic [15:0]  interface_rdata;
  logic         interface_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  head_sram_if_master #(.BANK_DEPTH(32), .DATA_WIDTH(128)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wr           (req_wr),
    .req_line         (req_line),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_wr          (resp_wr),
    .resp_rdata       (resp_rdata),
    .interface_addr   (interface_addr),
    .interface_ren    (interface_ren),
    .interface_wen    (interface_wen),
    .interface_wdata  (interface_wdata),
    .interface_rdata  (interface_rdata),
    .interface_rvalid (interface_rvalid)
  );

  // head_sram port model plus an injectable stray return strobe.
  logic [15:0] mem [0:255];
  logic        p1_v, m_rvalid, stray_v;
  logic [15:0] p1_d, m_rdata, stray_d;

  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;

  always @(posedge clk) begin
    if (interface_wen) mem[interface_addr] <= interface_wdata;
    p1_v     <= interface_ren;
    p1_d     <= mem[interface_addr];
    m_rvalid <= p1_v;
    m_rdata  <= p1_d;
  end

  assign interface_rvalid = m_rvalid | stray_v;
  assign interface_rdata  = stray_v ? stray_d : m_rdata;

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_line = '0; req_wdata = '0;
    resp_ready = 1'b0; stray_v = 1'b0; stray_d = '0;
    p1_v = 1'b0; m_rvalid = 1'b0; p1_d = '0; m_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_wr, interface_ren, interface_wen} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10000", {req_ready, resp_valid, resp_wr, interface_ren, interface_wen});
    end
    checks++;
    if ({interface_addr, interface_wdata, resp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp all 0", interface_addr, interface_wdata, resp_rdata);
    end
    rstn = 1'b1;
  endtask

  // Write a line; hold_valid keeps req_valid high with scrambled inputs during the transfer.
  task automatic test_write(input logic [4:0] line, input logic [127:0] data, input bit hold_valid);
    logic [15:0] beat;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_line = line; req_wdata = data;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_pre got %b exp 1", req_ready); end
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (hold_valid && k < 9) begin
        req_wdata = ~data ^ 128'(k);
        req_line  = ~line;
        req_wr    = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      checks++;
      if ({interface_wen, interface_ren, resp_valid, req_ready} !== {(k <= 8), 1'b0, (k == 9), 1'b0}) begin
        errors++;
        $display("FAIL wr_ctrl cycle A+%0d got wen/ren/rv/rr=%b exp %b", k,
                 {interface_wen, interface_ren, resp_valid, req_ready}, {(k <= 8), 1'b0, (k == 9), 1'b0});
      end
      if (k <= 8) begin
        beat = data[16*(k-1) +: 16];
        checks++;
        if ({interface_addr, interface_wdata} !== {line, 3'(k-1), beat}) begin
          errors++;
          $display("FAIL wr_beat%0d got addr=%h wdata=%h exp addr=%h wdata=%h", k-1,
                   interface_addr, interface_wdata, {line, 3'(k-1)}, beat);
        end
      end
    end
    checks++;
    if (resp_wr !== 1'b1) begin errors++; $display("FAIL wr_resp_wr got %b exp 1", resp_wr); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid, interface_wen, interface_addr} !== {3'b100, line, 3'd7}) begin
      errors++;
      $display("FAIL wr_idle got rr/rv/wen=%b addr=%h exp 100 addr=%h",
               {req_ready, resp_valid, interface_wen}, interface_addr, {line, 3'd7});
    end
  endtask

  // Read a line; resp_ready is withheld for hold cycles once resp_valid rises.
  task automatic test_read(input logic [4:0] line, input logic [127:0] exp_data, input int hold);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_line = line; req_wdata = '0;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({interface_ren, interface_wen, resp_valid, req_ready} !== {(k <= 8), 3'b000}) begin
        errors++;
        $display("FAIL rd_ctrl cycle A+%0d got ren/wen/rv/rr=%b exp %b", k,
                 {interface_ren, interface_wen, resp_valid, req_ready}, {(k <= 8), 3'b000});
      end
      if (k <= 8) begin
        checks++;
        if (interface_addr !== {line, 3'(k-1)}) begin
          errors++;
          $display("FAIL rd_addr beat%0d got %h exp %h", k-1, interface_addr, {line, 3'(k-1)});
        end
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_wr, resp_rdata} !== {3'b100, exp_data}) begin
        errors++;
        $display("FAIL rd_resp A+%0d got rv/rr/wr=%b data=%h exp 100 data=%h", 11 + h,
                 {resp_valid, req_ready, resp_wr}, resp_rdata, exp_data);
      end
      if (h == hold) resp_ready = 1'b1;
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid, interface_ren} !== 3'b100) begin
      errors++;
      $display("FAIL rd_idle got rr/rv/ren=%b exp 100", {req_ready, resp_valid, interface_ren});
    end
  endtask

  task automatic test_stray_rvalid();
    @(negedge clk);
    stray_v = 1'b1; stray_d = 16'hDEAD;
    @(negedge clk);
    stray_v = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stray_idle got rr/rv=%b exp 10", {req_ready, resp_valid});
    end
  endtask

  // Reset asserted while beat 3 of a write is on the interface.
  task automatic test_reset_mid(input logic [4:0] line, input logic [127:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_line = line; req_wdata = data;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    checks++;
    if ({interface_wen, interface_addr} !== {1'b1, line, 3'd3}) begin
      errors++;
      $display("FAIL abort_pre got wen=%b addr=%h exp 1 %h", interface_wen, interface_addr, {line, 3'd3});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({interface_wen, interface_ren, req_ready, resp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_async got wen/ren/rr/rv=%b exp 0010",
               {interface_wen, interface_ren, req_ready, resp_valid});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({interface_wen, req_ready, resp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL abort_after got wen/rr/rv=%b exp 010", {interface_wen, req_ready, resp_valid});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write(5'd5, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b0);
    test_read(5'd5, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0);
    test_read(5'd5, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 4);
    test_write(5'd9, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 1'b1);
    test_read(5'd9, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 0);
    test_stray_rvalid();
    test_read(5'd9, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 1);
    test_write(5'd31, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    test_reset_mid(5'd31, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567);
    // Beats 0..2 of the aborted write landed; beats 3..7 keep the earlier line.
    test_read(5'd31, 128'h1111_2222_3333_4444_5555_FFFF_0123_4567, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
